// File: rtl/drop_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : drop_ctrl_if
// Description : Handshake bundle between the drop controller, the player
//               inputs, the fall timer and the board engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface drop_ctrl_if #(
    parameter int ROW_W = 5
);
    // Player / timer / board inputs to the controller
    logic             game_active;
    logic             timeout;
    logic             soft_drop;
    logic             hard_drop;
    logic             move_ack;
    logic             move_ok;
    logic             lock_ack;
    // Controller outputs
    logic             move_req;
    logic             lock_req;
    logic             fall_rst;
    logic             score_valid;
    logic [ROW_W-1:0] score_rows;
    logic             err;

    // Controller side: issues move/lock requests
    modport master (
        input  game_active, timeout, soft_drop, hard_drop,
        input  move_ack, move_ok, lock_ack,
        output move_req, lock_req, fall_rst, score_valid, score_rows, err
    );

    // Board / environment side
    modport slave (
        output game_active, timeout, soft_drop, hard_drop,
        output move_ack, move_ok, lock_ack,
        input  move_req, lock_req, fall_rst, score_valid, score_rows, err
    );
endinterface
`default_nettype wire

// File: rtl/drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : drop_ctrl
// Description : Turns fall-timer expiries and soft/hard drop pulses into
//               move-down / lock requests to the board engine, restarts the
//               fall timer and reports rows dropped by the player.
// Revision    : 1.0 - initial release
// ============================================================================
module drop_ctrl #(
    parameter int ROW_W       = 5,
    parameter int ACK_TIMEOUT = 64
) (
    input  wire logic    clk,
    input  wire logic    rst,
    drop_ctrl_if.master  bus
);

    localparam int               WD_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(ACK_TIMEOUT - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_MOVE = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    state_t             state_q,       state_d;
    logic               hard_q,        hard_d;
    logic               player_q,      player_d;
    logic [ROW_W-1:0]   rows_q,        rows_d;
    logic [WD_W-1:0]    wd_q,          wd_d;
    logic               move_req_q,    move_req_d;
    logic               lock_req_q,    lock_req_d;
    logic               fall_rst_q,    fall_rst_d;
    logic               score_valid_q, score_valid_d;
    logic [ROW_W-1:0]   score_rows_q,  score_rows_d;
    logic               err_q,         err_d;

    logic               w_waiting;
    logic [ROW_W-1:0]   w_rows_inc;

    // A request is outstanding and the board has not answered this cycle
    assign w_waiting  = (move_req_q & ~bus.move_ack) | (lock_req_q & ~bus.lock_ack);
    // Saturating increment of the dropped-row counter
    assign w_rows_inc = (rows_q == ROW_MAX) ? rows_q : rows_q + 1'b1;

    // State register and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            hard_q        <= 1'b0;
            player_q      <= 1'b0;
            rows_q        <= '0;
            wd_q          <= '0;
            move_req_q    <= 1'b0;
            lock_req_q    <= 1'b0;
            fall_rst_q    <= 1'b0;
            score_valid_q <= 1'b0;
            score_rows_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hard_q        <= hard_d;
            player_q      <= player_d;
            rows_q        <= rows_d;
            wd_q          <= wd_d;
            move_req_q    <= move_req_d;
            lock_req_q    <= lock_req_d;
            fall_rst_q    <= fall_rst_d;
            score_valid_q <= score_valid_d;
            score_rows_q  <= score_rows_d;
            err_q         <= err_d;
        end
    end

    // Next-state, handshake and watchdog logic
    always_comb begin
        state_d       = state_q;
        hard_d        = hard_q;
        player_d      = player_q;
        rows_d        = rows_q;
        wd_d          = w_waiting ? wd_q + 1'b1 : '0;
        move_req_d    = move_req_q;
        lock_req_d    = lock_req_q;
        fall_rst_d    = 1'b0;
        score_valid_d = 1'b0;
        score_rows_d  = '0;
        err_d         = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.game_active) begin
                    state_d    = S_WAIT;
                    fall_rst_d = 1'b1;
                end
            end

            S_WAIT: begin
                // A timeout seen while the restart pulse is still out is the
                // stale expiry of the previous period, so it is masked.
                if (!bus.game_active) begin
                    state_d  = S_IDLE;
                    rows_d   = '0;
                    hard_d   = 1'b0;
                    player_d = 1'b0;
                end else if (bus.hard_drop) begin
                    hard_d     = 1'b1;
                    player_d   = 1'b0;
                    move_req_d = 1'b1;
                    state_d    = S_MOVE;
                end else if (bus.timeout && !fall_rst_q) begin
                    player_d   = 1'b0;
                    move_req_d = 1'b1;
                    state_d    = S_MOVE;
                end else if (bus.soft_drop) begin
                    player_d   = 1'b1;
                    move_req_d = 1'b1;
                    state_d    = S_MOVE;
                end
            end

            S_MOVE: begin
                if (move_req_q) begin
                    if (bus.move_ack) begin
                        move_req_d = 1'b0;
                        if (bus.move_ok) begin
                            if (hard_q || player_q) begin
                                rows_d = w_rows_inc;
                            end
                            if (!bus.game_active) begin
                                state_d  = S_IDLE;
                                rows_d   = '0;
                                hard_d   = 1'b0;
                                player_d = 1'b0;
                            end else if (!hard_q) begin
                                fall_rst_d = 1'b1;
                                state_d    = S_WAIT;
                            end
                        end else if (!bus.game_active) begin
                            state_d  = S_IDLE;
                            rows_d   = '0;
                            hard_d   = 1'b0;
                            player_d = 1'b0;
                        end else begin
                            lock_req_d = 1'b1;
                            state_d    = S_LOCK;
                        end
                    end
                end else begin
                    // Idle cycle between hard-drop steps
                    if (!bus.game_active) begin
                        state_d  = S_IDLE;
                        rows_d   = '0;
                        hard_d   = 1'b0;
                        player_d = 1'b0;
                    end else begin
                        move_req_d = 1'b1;
                    end
                end
            end

            S_LOCK: begin
                if (lock_req_q && bus.lock_ack) begin
                    lock_req_d    = 1'b0;
                    score_valid_d = 1'b1;
                    score_rows_d  = rows_q;
                    rows_d        = '0;
                    hard_d        = 1'b0;
                    player_d      = 1'b0;
                    if (bus.game_active) begin
                        fall_rst_d = 1'b1;
                        state_d    = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Board never answered: abandon the request and park in IDLE
        if (w_waiting && (wd_q == WD_LAST)) begin
            err_d         = 1'b1;
            move_req_d    = 1'b0;
            lock_req_d    = 1'b0;
            state_d       = S_IDLE;
            rows_d        = '0;
            hard_d        = 1'b0;
            player_d      = 1'b0;
            wd_d          = '0;
            fall_rst_d    = 1'b0;
            score_valid_d = 1'b0;
            score_rows_d  = '0;
        end
    end

    assign bus.move_req    = move_req_q;
    assign bus.lock_req    = lock_req_q;
    assign bus.fall_rst    = fall_rst_q;
    assign bus.score_valid = score_valid_q;
    assign bus.score_rows  = score_rows_q;
    assign bus.err         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_drop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_drop_ctrl
// Description : Self-checking bench for drop_ctrl: vector table, directed
//               corner sequences and a randomized piece-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drop_ctrl;

    localparam int ACK_TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    drop_ctrl_if #(.ROW_W(5)) bus ();
    drop_ctrl_if #(.ROW_W(2)) bus2 ();

    assign bus2.game_active = bus.game_active;
    assign bus2.timeout     = bus.timeout;
    assign bus2.soft_drop   = bus.soft_drop;
    assign bus2.hard_drop   = bus.hard_drop;
    assign bus2.move_ack    = bus.move_ack;
    assign bus2.move_ok     = bus.move_ok;
    assign bus2.lock_ack    = bus.lock_ack;

    drop_ctrl #(.ROW_W(5), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    drop_ctrl #(.ROW_W(2), .ACK_TIMEOUT(ACK_TIMEOUT)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int nchecks = 0;
    int errs    = 0;

    // Passive monitors: pulse counters and narrow-instance agreement
    int   falls = 0, mreqs = 0, b2b = 0, diff2 = 0;
    logic fall_prev = 1'b0, mreq_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.fall_rst && fall_prev) b2b++;
        if (bus.fall_rst) falls++;
        if (bus.move_req && !mreq_prev) mreqs++;
        if ({bus.move_req, bus.lock_req, bus.fall_rst, bus.score_valid, bus.err} !==
            {bus2.move_req, bus2.lock_req, bus2.fall_rst, bus2.score_valid, bus2.err}) diff2++;
        fall_prev = bus.fall_rst;
        mreq_prev = bus.move_req;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Wait (bounded) for move_req or lock_req to be high
    task automatic wait_req(input bit lock, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ((lock ? bus.lock_req : bus.move_req) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check(lock ? "lock_req_wait" : "move_req_wait", 0, 1);
    endtask

    task automatic do_move(input bit ok, input int lat);
        bit seen;
        wait_req(1'b0, seen);
        if (seen) begin
            repeat (lat) tick();
            if (lat > 0) check("move_req_held", bus.move_req, 1);
            bus.move_ack = 1'b1;
            bus.move_ok  = ok;
            tick();
            bus.move_ack = 1'b0;
            bus.move_ok  = 1'b0;
            check("move_req_drop", bus.move_req, 0);
        end
    endtask

    task automatic do_lock(input int lat);
        bit seen;
        wait_req(1'b1, seen);
        if (seen) begin
            repeat (lat) tick();
            bus.lock_ack = 1'b1;
            tick();
            bus.lock_ack = 1'b0;
        end
    endtask

    typedef struct {
        logic       ga, to, sd, hd, mack, mok, lack;
        logic       mreq, lreq, fall, sv;
        logic [4:0] rows;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int  f0, m0, rows, limit, steps, act, n, lat;
        bit  locked;

        bus.game_active = 1'b0;
        bus.timeout     = 1'b0;
        bus.soft_drop   = 1'b0;
        bus.hard_drop   = 1'b0;
        bus.move_ack    = 1'b0;
        bus.move_ok     = 1'b0;
        bus.lock_ack    = 1'b0;

        // ------------------------------------------------------------ reset
        repeat (3) tick();
        check("reset_outs", {bus.move_req, bus.lock_req, bus.fall_rst, bus.score_valid,
                             bus.score_rows, bus.err}, 0);
        rst = 1'b0;

        // --------------------------------------------- vector table (1, 2)
        //            ga to sd hd ma mo la   mreq lreq fall sv rows
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 0, 0, 1, 1, 0,  0, 0, 1, 0, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0}); // stale timeout masked
        tbl.push_back('{1, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0});
        tbl.push_back('{1, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0}); // hard in MOVE dropped
        tbl.push_back('{1, 1, 0, 0, 1, 0, 0,  0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0}); // soft in LOCK dropped
        tbl.push_back('{1, 1, 0, 0, 0, 0, 1,  0, 0, 1, 1, 3});
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            bus.game_active = tbl[i].ga;
            bus.timeout     = tbl[i].to;
            bus.soft_drop   = tbl[i].sd;
            bus.hard_drop   = tbl[i].hd;
            bus.move_ack    = tbl[i].mack;
            bus.move_ok     = tbl[i].mok;
            bus.lock_ack    = tbl[i].lack;
            tick();
            check($sformatf("vec%0d", i),
                  {bus.move_req, bus.lock_req, bus.fall_rst, bus.score_valid, bus.score_rows},
                  {tbl[i].mreq, tbl[i].lreq, tbl[i].fall, tbl[i].sv, tbl[i].rows});
            if (tbl[i].sv) check($sformatf("vec%0d_rows2", i), bus2.score_rows,
                                 sat(int'(tbl[i].rows), 3));
        end
        bus.soft_drop = 1'b0; bus.hard_drop = 1'b0; bus.move_ack = 1'b0;
        bus.move_ok = 1'b0; bus.lock_ack = 1'b0; bus.timeout = 1'b0;

        // --------------------------- hard drop, 5 free rows then blocked (3, 5)
        f0 = falls; m0 = mreqs;
        bus.hard_drop = 1'b1; tick(); bus.hard_drop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_move(1'b1, 0);
            if (i == 0) check("hard_no_fall", bus.fall_rst, 0);
        end
        do_move(1'b0, 0);
        do_lock(0);
        check("hard_score_valid", bus.score_valid, 1);
        check("hard_score_rows", bus.score_rows, 5);
        check("hard_score_rows_sat2", bus2.score_rows, 3);
        tick();
        check("hard_handshakes", mreqs - m0, 6);
        check("hard_fall_count", falls - f0, 1);
        check("hard_fall_width", bus.fall_rst, 0);

        // ----------------- timeout + hard same cycle, soft during MOVE (4)
        bus.timeout = 1'b1; bus.hard_drop = 1'b1; tick(); bus.hard_drop = 1'b0;
        check("tie_move_req", bus.move_req, 1);
        do_move(1'b1, 0);
        check("tie_hard_path_no_fall", bus.fall_rst, 0);
        bus.soft_drop = 1'b1; tick(); bus.soft_drop = 1'b0;
        do_move(1'b0, 1);
        do_lock(1);
        bus.timeout = 1'b0;
        check("tie_score_rows", bus.score_rows, 1);
        tick();
        check("tie_settled", {bus.move_req, bus.fall_rst}, 0);

        // --------------------------------------------- watchdog (6)
        bus.timeout = 1'b1; tick(); bus.timeout = 1'b0;
        check("wd_req_up", bus.move_req, 1);
        repeat (ACK_TIMEOUT - 1) tick();
        check("wd_before_limit", {bus.move_req, bus.err}, 2'b10);
        tick();
        check("wd_at_limit", {bus.move_req, bus.err}, 2'b01);
        tick();
        check("wd_idle_restart", {bus.fall_rst, bus.err}, 2'b11);

        // --------------------------------------- async reset mid-LOCK (6)
        tick();
        bus.timeout = 1'b1; tick(); bus.timeout = 1'b0;
        do_move(1'b0, 0);
        check("lock_before_rst", bus.lock_req, 1);
        rst = 1'b1;
        #2;
        check("rst_async_outs", {bus.move_req, bus.lock_req, bus.fall_rst, bus.score_valid,
                                 bus.score_rows, bus.err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("rst_release_restart", {bus.fall_rst, bus.err}, 2'b10);

        // ------------------------------------------- randomized pieces
        for (int p = 0; p < 60; p++) begin
            rows   = 0;
            steps  = 0;
            locked = 1'b0;
            limit  = $urandom_range(1, 60);
            while (!locked) begin
                tick(); tick();
                f0  = falls;
                m0  = mreqs;
                act = $urandom_range(0, 9);
                lat = $urandom_range(0, 3);
                steps++;
                if (act == 0) begin
                    n = $urandom_range(0, 40);
                    bus.hard_drop = 1'b1; tick(); bus.hard_drop = 1'b0;
                    for (int k = 0; k < n; k++) begin
                        do_move(1'b1, $urandom_range(0, 3));
                        rows++;
                    end
                    do_move(1'b0, lat);
                    check("rnd_hard_handshakes", mreqs - m0, n + 1);
                    locked = 1'b1;
                end else begin
                    if (act <= 4) bus.timeout = 1'b1;
                    if (act >= 4) bus.soft_drop = 1'b1;
                    tick();
                    bus.timeout   = 1'b0;
                    bus.soft_drop = 1'b0;
                    if (steps >= limit) begin
                        do_move(1'b0, lat);
                        locked = 1'b1;
                    end else begin
                        do_move(1'b1, lat);
                        if (act >= 5) rows++;
                        check("rnd_step_fall", bus.fall_rst, 1);
                        tick();
                        check("rnd_step_counts", {falls - f0, mreqs - m0}, {32'd1, 32'd1});
                    end
                end
            end
            do_lock($urandom_range(0, 3));
            check("rnd_score_valid", bus.score_valid, 1);
            check("rnd_score_rows", bus.score_rows, sat(rows, 31));
            check("rnd_score_rows2", bus2.score_rows, sat(rows, 3));
            check("rnd_lock_fall", bus.fall_rst, 1);
        end

        tick();
        check("fall_back_to_back", b2b, 0);
        check("narrow_instance_agree", diff2, 0);
        check("no_err", bus.err, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, errs);
        $finish;
    end

endmodule
`default_nettype wire
